// File: rtl/spi_register_port.sv
// SPI mode-0 slave register port. Oversamples SCK/CS_N/MOSI in the i_Clock
// domain, assembles 16-bit register numbers and 8-bit values, and issues
// one-cycle write strobes. Burst bytes auto-increment the register number.
// Each frame returns a status byte {E, WC[6:0]} on MISO.
module spi_register_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SPI_SCK,
  input  logic        i_SPI_CS_N,
  input  logic        i_SPI_MOSI,
  output logic        o_SPI_MISO,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterWriteNumber,
  output logic [7:0]  o_RegisterWriteValue,
  output logic        o_FrameError
);

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall, active;

  logic        armed_q, armed_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [15:0] num_q, num_d;
  logic [7:0]  val_q, val_d;
  logic        we_q, we_d;
  logic        ferr_q, ferr_d;
  logic [6:0]  wc_q, wc_d;
  logic        err_q, err_d;
  logic [7:0]  miso_q, miso_d;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  // Bits count only once CS_N has been seen high after reset, so a frame
  // already in progress at reset release is ignored.
  assign active   = armed_q & ~cs_s;

  // Synchronize the SPI pins and keep a one-cycle-delayed copy for edge detection.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_N};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  // Frame decode: bit capture, write issue, frame-end checking, status and MISO shifting.
  always_comb begin
    armed_d   = armed_q | cs_s;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    num_d     = num_q;
    val_d     = val_q;
    we_d      = 1'b0;
    ferr_d    = 1'b0;
    wc_d      = wc_q;
    err_d     = err_q;
    miso_d    = miso_q;

    if (cs_rise) begin
      // Only a count of 0 (no bits) or 24 (just after a complete byte) is a clean end.
      ferr_d    = (bit_cnt_q != 5'd0) && (bit_cnt_q != 5'd24);
      bit_cnt_d = 5'd0;
      shift_d   = '0;
      miso_d    = '0;
    end else if (sck_rise && active) begin
      shift_d = {shift_q[21:0], mosi_s};
      if (bit_cnt_q == 5'd23 || bit_cnt_q == 5'd31) begin
        // The 23 bits already held are number[15:0] followed by value[7:1].
        num_d     = (bit_cnt_q == 5'd23) ? shift_q[22:7] : num_q + 16'd1;
        val_d     = {shift_q[6:0], mosi_s};
        we_d      = 1'b1;
        bit_cnt_d = 5'd24;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    if (cs_fall) begin
      miso_d = {err_q, wc_q};
      err_d  = 1'b0;
    end else if (sck_fall && active) begin
      miso_d = {miso_q[6:0], 1'b0};
    end

    if (we_d) begin
      wc_d = wc_q + 7'd1;
    end
    // A new error wins over the clear-on-latch so it is reported next frame.
    if (ferr_d) begin
      err_d = 1'b1;
    end
  end

  // Register the frame state and outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      num_q     <= '0;
      val_q     <= '0;
      we_q      <= 1'b0;
      ferr_q    <= 1'b0;
      wc_q      <= '0;
      err_q     <= 1'b0;
      miso_q    <= '0;
    end else begin
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      num_q     <= num_d;
      val_q     <= val_d;
      we_q      <= we_d;
      ferr_q    <= ferr_d;
      wc_q      <= wc_d;
      err_q     <= err_d;
      miso_q    <= miso_d;
    end
  end

  assign o_RegisterWriteEnable = we_q;
  assign o_RegisterWriteNumber = num_q;
  assign o_RegisterWriteValue  = val_q;
  assign o_FrameError          = ferr_q;
  assign o_SPI_MISO            = miso_q[7];

endmodule
